cam_pattern_tx: RTL and testbench
=================================

// Module: cam_pattern_tx
// PURPOSE
//  Camera-side transmitter: emulates the 8-bit parallel camera bus (VSYNC/HREF/byte data) on CamPCLK.
//  Emits RGB565 test frames, high byte first, so the capture/line-buffer path can be exercised without a sensor.
//  Sits in place of the sensor pins; its outputs drive the capture block's CamVSYNC/HREF/PixData inputs directly.
// PARAMETERS
//  H_ACTIVE     640      active pixels per line (each pixel = 2 bytes = 2 CamPCLK)
//  H_BLANK      144      CamPCLK cycles with HREF low after each active line
//  V_ACTIVE     480      active lines per frame
//  VSYNC_LINES  3        line periods with CamVSYNC high
//  V_BACK       17       blank line periods between VSYNC fall and first active line
//  V_FRONT      10       blank line periods after last active line
//  SOLID_COLOR  16'hF800 RGB565 value for pattern 3
// PORTS
//  CamPCLK      in   1   pixel-byte clock; all logic on rising edge
//  resetN       in   1   asynchronous, active-low reset
//  enable       in   1   level; start/continue frame generation
//  patternSel   in   2   0 colour bars, 1 column ramp, 2 8x8 checker, 3 solid
//  CamVSYNC     out  1   frame sync, high during VSYNC_LINES line periods
//  HREF         out  1   high while active bytes valid
//  PixData      out  8   byte data; 8'h00 whenever HREF low
//  frameDone    out  1   one-cycle pulse on last cycle of V_FRONT
//  lineCount    out  10  active line index of current/last line
// BEHAVIOUR
//  Reset (async, resetN=0): state IDLE, CamVSYNC=0, HREF=0, PixData=0, frameDone=0, lineCount=0, all counters 0.
//  Line period LINE_LEN = 2*H_ACTIVE + H_BLANK cycles; all vertical durations counted in whole line periods.
//  States: IDLE -> VSYNC -> VBACK -> ACTIVE -> VFRONT -> (VSYNC | IDLE).
//   IDLE: outputs low; enable=1 -> VSYNC next cycle.
//   VSYNC: CamVSYNC=1 for VSYNC_LINES*LINE_LEN cycles, HREF=0.
//   VBACK: V_BACK*LINE_LEN cycles, all outputs low.
//   ACTIVE: per line HREF=1 for 2*H_ACTIVE cycles then 0 for H_BLANK; repeat V_ACTIVE lines.
//   VFRONT: V_FRONT*LINE_LEN cycles low; last cycle frameDone=1; enable=1 -> VSYNC, else IDLE.
//  enable deassert mid-frame: current frame completes; checked only at end of VFRONT.
//  patternSel sampled at VSYNC entry only; change mid-frame has no effect until next frame.
//  Byte order: even byte (byteCnt[0]=0) = pixel[15:8], odd = pixel[7:0]; x = byteCnt>>1.
//  Outputs registered: HREF, PixData, CamVSYNC change together; HREF and first byte on same edge.
//  Patterns (x column, y = lineCount):
//   0 bars: bar = x*8/H_ACTIVE; FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000.
//   1 ramp: pixel = x[15:0] (zero-extended).
//   2 checker: (x[3]^y[3]) ? FFFF : 0000.
//   3 solid: SOLID_COLOR.
//  Counters: byteCnt wraps at LINE_LEN-1 -> 0; lineCnt wraps per state; no overflow beyond params.
//  lineCount increments at end of each active line; reset to 0 at VSYNC entry.
//  Width rule: counters sized with $clog2 of max value; bar index via multiply, no divider.
// STRUCTURE
//  Package cam_pkg: state enum, RGB565 bar colour constants, pattern-select codes.
//  Sub-module cam_pattern_gen: combinational (x, y, patternSel) -> 16-bit RGB565 pixel; top holds FSM,
//   counters and output registers.
// TESTING (params H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1)
//  Reset then enable=1 -> CamVSYNC high exactly 20 cycles, then 20 low, then HREF high 16 cycles.
//  patternSel=0 -> first line bytes FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
//  patternSel=1 -> line bytes 00,00,00,01,...,00,07; HREF low 4 cycles; PixData=00 while low.
//  enable=0 during ACTIVE line 2 -> all 4 lines sent, frameDone pulse, then IDLE, CamVSYNC stays 0.
//  Change patternSel 0->3 mid-frame -> bars persist; next frame all pixels F800.
//  Assert resetN=0 mid-HREF -> HREF/PixData/CamVSYNC 0 same cycle (async); restart frame from VSYNC.
//  Bench: capture block fed by this module reassembles 16-bit pixels matching pattern model.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera-bus test-pattern transmitter.
package cam_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VSYNC,
      ST_VBACK,
      ST_ACTIVE,
      ST_VFRONT
   } cam_state_e;

   typedef enum logic [1:0] {
      PAT_BARS    = 2'd0,
      PAT_RAMP    = 2'd1,
      PAT_CHECKER = 2'd2,
      PAT_SOLID   = 2'd3
   } pattern_e;

   localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [15:0] BAR_CYAN    = 16'h07FF;
   localparam logic [15:0] BAR_GREEN   = 16'h07E0;
   localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [15:0] BAR_RED     = 16'hF800;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;

   function automatic logic [15:0] bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    return BAR_WHITE;
         3'd1:    return BAR_YELLOW;
         3'd2:    return BAR_CYAN;
         3'd3:    return BAR_GREEN;
         3'd4:    return BAR_MAGENTA;
         3'd5:    return BAR_RED;
         3'd6:    return BAR_BLUE;
         default: return BAR_BLACK;
      endcase
   endfunction

   // Bits needed to hold 0..max_val; never less than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// Combinational RGB565 test-pattern source: (column, line, pattern) -> pixel.
module cam_pattern_gen
   import cam_pkg::*;
#(
   parameter int          H_ACTIVE    = 640,
   parameter logic [15:0] SOLID_COLOR = 16'hF800,
   parameter int          X_W         = cnt_width(H_ACTIVE - 1)
) (
   input  logic [X_W-1:0] x,
   input  logic [9:0]     y,
   input  pattern_e       sel,
   output logic [15:0]    pixel
);

   logic [15:0] x_ext;
   logic [31:0] x_times8;
   logic [2:0]  bar;

   // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
   always_comb begin
      x_ext    = 16'(x);
      x_times8 = 32'(x) << 3;
      // Bar index = floor(x*8/H_ACTIVE), found by comparing against constant thresholds.
      bar = '0;
      for (int k = 1; k < 8; k++) begin
         if (x_times8 >= 32'(k * H_ACTIVE)) bar = bar + 3'd1;
      end

      pixel = SOLID_COLOR;
      case (sel)
         PAT_BARS:    pixel = bar_color(bar);
         PAT_RAMP:    pixel = x_ext;
         PAT_CHECKER: pixel = (x_ext[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
         PAT_SOLID:   pixel = SOLID_COLOR;
         default:     pixel = SOLID_COLOR;
      endcase
   end

endmodule

// File: rtl/cam_pattern_tx.sv
// Emulates an 8-bit parallel camera bus (VSYNC/HREF/bytes) carrying RGB565 test frames,
// high byte first. Outputs are registered from next-state values so they align with state.
module cam_pattern_tx
   import cam_pkg::*;
#(
   parameter int          H_ACTIVE    = 640,
   parameter int          H_BLANK     = 144,
   parameter int          V_ACTIVE    = 480,
   parameter int          VSYNC_LINES = 3,
   parameter int          V_BACK      = 17,
   parameter int          V_FRONT     = 10,
   parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
   input  logic       CamPCLK,
   input  logic       resetN,
   input  logic       enable,
   input  logic [1:0] patternSel,
   output logic       CamVSYNC,
   output logic       HREF,
   output logic [7:0] PixData,
   output logic       frameDone,
   output logic [9:0] lineCount
);

   localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
   localparam int MAX_LINES = max_int(max_int(V_ACTIVE, VSYNC_LINES), max_int(V_BACK, V_FRONT));
   localparam int BYTE_W    = cnt_width(LINE_LEN - 1);
   localparam int LINE_W    = cnt_width(MAX_LINES - 1);
   localparam int X_W       = cnt_width(H_ACTIVE - 1);

   localparam logic [BYTE_W-1:0] BYTE_LAST   = BYTE_W'(LINE_LEN - 1);
   localparam logic [BYTE_W-1:0] HREF_BYTES  = BYTE_W'(2 * H_ACTIVE);
   localparam logic [LINE_W-1:0] VSYNC_LAST  = LINE_W'(VSYNC_LINES - 1);
   localparam logic [LINE_W-1:0] VBACK_LAST  = LINE_W'(V_BACK - 1);
   localparam logic [LINE_W-1:0] ACTIVE_LAST = LINE_W'(V_ACTIVE - 1);
   localparam logic [LINE_W-1:0] VFRONT_LAST = LINE_W'(V_FRONT - 1);

   cam_state_e        state_q, state_d;
   logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
   pattern_e          pattern_q, pattern_d;
   logic              vsync_q, vsync_d;
   logic              href_q, href_d;
   logic [7:0]        pix_data_q, pix_data_d;
   logic              frame_done_q, frame_done_d;
   logic [9:0]        line_count_q, line_count_d;

   logic              line_end;
   logic [LINE_W-1:0] lines_last;
   logic [X_W-1:0]    pix_x;
   logic [15:0]       pixel;

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      line_cnt_d = line_cnt_q;
      pattern_d  = pattern_q;
      line_end   = (byte_cnt_q == BYTE_LAST);
      lines_last = '0;
      case (state_q)
         ST_VSYNC:  lines_last = VSYNC_LAST;
         ST_VBACK:  lines_last = VBACK_LAST;
         ST_ACTIVE: lines_last = ACTIVE_LAST;
         ST_VFRONT: lines_last = VFRONT_LAST;
         default:   lines_last = '0;
      endcase

      if (state_q == ST_IDLE) begin
         byte_cnt_d = '0;
         line_cnt_d = '0;
         if (enable) begin
            state_d   = ST_VSYNC;
            pattern_d = pattern_e'(patternSel);
         end
      end else if (!line_end) begin
         byte_cnt_d = byte_cnt_q + 1'b1;
      end else begin
         byte_cnt_d = '0;
         if (line_cnt_q != lines_last) begin
            line_cnt_d = line_cnt_q + 1'b1;
         end else begin
            line_cnt_d = '0;
            case (state_q)
               ST_VSYNC:  state_d = ST_VBACK;
               ST_VBACK:  state_d = ST_ACTIVE;
               ST_ACTIVE: state_d = ST_VFRONT;
               ST_VFRONT: begin
                  // enable is only consulted here, so a frame in flight always completes.
                  if (enable) begin
                     state_d   = ST_VSYNC;
                     pattern_d = pattern_e'(patternSel);
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
               default:   state_d = ST_IDLE;
            endcase
         end
      end
   end

   assign line_count_d = (state_d == ST_ACTIVE)                          ? 10'(line_cnt_d) :
                         (state_d == ST_VSYNC && state_q != ST_VSYNC)    ? 10'd0 :
                                                                           line_count_q;
   assign pix_x = X_W'(byte_cnt_d >> 1);

   cam_pattern_gen #(
      .H_ACTIVE    (H_ACTIVE),
      .SOLID_COLOR (SOLID_COLOR),
      .X_W         (X_W)
   ) u_pattern_gen (
      .x     (pix_x),
      .y     (line_count_d),
      .sel   (pattern_q),
      .pixel (pixel)
   );

   always_comb begin
      vsync_d      = (state_d == ST_VSYNC);
      href_d       = (state_d == ST_ACTIVE) && (byte_cnt_d < HREF_BYTES);
      frame_done_d = (state_d == ST_VFRONT) && (line_cnt_d == VFRONT_LAST) &&
                     (byte_cnt_d == BYTE_LAST);
      pix_data_d   = 8'h00;
      if (href_d) pix_data_d = byte_cnt_d[0] ? pixel[7:0] : pixel[15:8];
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CamPCLK or negedge resetN) begin
      if (!resetN) begin
         state_q      <= ST_IDLE;
         byte_cnt_q   <= '0;
         line_cnt_q   <= '0;
         pattern_q    <= PAT_BARS;
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         pix_data_q   <= 8'h00;
         frame_done_q <= 1'b0;
         line_count_q <= 10'd0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         line_cnt_q   <= line_cnt_d;
         pattern_q    <= pattern_d;
         vsync_q      <= vsync_d;
         href_q       <= href_d;
         pix_data_q   <= pix_data_d;
         frame_done_q <= frame_done_d;
         line_count_q <= line_count_d;
      end
   end

   assign CamVSYNC  = vsync_q;
   assign HREF      = href_q;
   assign PixData   = pix_data_q;
   assign frameDone = frame_done_q;
   assign lineCount = line_count_q;

endmodule

// File: tb/tb_cam_pattern_tx.sv
// Bench for cam_pattern_tx: frame-timeline model checked every cycle plus directed scenarios.
module tb_cam_pattern_tx;

   localparam int HA       = 8;
   localparam int HB       = 4;
   localparam int VA       = 4;
   localparam int VSL      = 1;
   localparam int VB       = 1;
   localparam int VF       = 1;
   localparam int LINE_LEN = 2 * HA + HB;
   localparam int FRAME    = (VSL + VB + VA + VF) * LINE_LEN;

   logic       clk = 1'b0;
   logic       resetN;
   logic       enable;
   logic [1:0] patternSel;
   logic       CamVSYNC;
   logic       HREF;
   logic [7:0] PixData;
   logic       frameDone;
   logic [9:0] lineCount;

   int n_checks = 0;
   int n_errors = 0;

   cam_pattern_tx #(
      .H_ACTIVE    (HA),
      .H_BLANK     (HB),
      .V_ACTIVE    (VA),
      .VSYNC_LINES (VSL),
      .V_BACK      (VB),
      .V_FRONT     (VF),
      .SOLID_COLOR (16'hF800)
   ) dut (
      .CamPCLK    (clk),
      .resetN     (resetN),
      .enable     (enable),
      .patternSel (patternSel),
      .CamVSYNC   (CamVSYNC),
      .HREF       (HREF),
      .PixData    (PixData),
      .frameDone  (frameDone),
      .lineCount  (lineCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] bar_ref(input int b);
      case (b)
         0:       return 16'hFFFF;
         1:       return 16'hFFE0;
         2:       return 16'h07FF;
         3:       return 16'h07E0;
         4:       return 16'hF81F;
         5:       return 16'hF800;
         6:       return 16'h001F;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [15:0] model_pixel(input int pat, input int x, input int y);
      case (pat)
         0:       return bar_ref(x * 8 / HA);
         1:       return 16'(x);
         2:       return ((((x / 8) + (y / 8)) % 2) == 1) ? 16'hFFFF : 16'h0000;
         default: return 16'hF800;
      endcase
   endfunction

   // Model: cycle position within the frame, counted from the first VSYNC cycle.
   bit m_run = 1'b0;
   int m_t   = 0;
   int m_pat = 0;

   initial begin : model_proc
      forever begin
         @(posedge clk or negedge resetN);
         if (!resetN) begin
            m_run = 1'b0;
            m_t   = 0;
         end else if (!m_run) begin
            if (enable) begin
               m_run = 1'b1;
               m_t   = 0;
               m_pat = int'(patternSel);
            end
         end else if (m_t == FRAME - 1) begin
            if (enable) begin
               m_t   = 0;
               m_pat = int'(patternSel);
            end else begin
               m_run = 1'b0;
            end
         end else begin
            m_t++;
         end
      end
   end

   initial begin : compare_proc
      int line, col, a;
      logic e_vs, e_href, e_fd, lc_known;
      logic [7:0]  e_pix;
      logic [15:0] p;
      int e_lc;
      forever begin
         @(negedge clk);
         line     = m_t / LINE_LEN;
         col      = m_t % LINE_LEN;
         a        = line - (VSL + VB);
         e_vs     = m_run && (line < VSL);
         e_href   = m_run && (a >= 0) && (a < VA) && (col < 2 * HA);
         e_fd     = m_run && (m_t == FRAME - 1);
         p        = model_pixel(m_pat, col / 2, a);
         e_pix    = e_href ? ((col % 2 == 0) ? p[15:8] : p[7:0]) : 8'h00;
         lc_known = 1'b0;
         e_lc     = 0;
         if (!resetN || (m_run && line < VSL + VB)) begin
            lc_known = 1'b1;
         end else if (m_run && a >= 0 && a < VA) begin
            lc_known = 1'b1;
            e_lc     = a;
         end
         check("CamVSYNC", CamVSYNC, e_vs);
         check("HREF", HREF, e_href);
         check("PixData", PixData, e_pix);
         check("frameDone", frameDone, e_fd);
         if (lc_known) check("lineCount", lineCount, 32'(e_lc));
      end
   end

   // Capture side: reassembles 16-bit pixels from the byte stream.
   int          frame_lines = 0;
   logic [15:0] cur_pix [HA];

   initial begin : capture_proc
      logic prev_href, prev_vs;
      logic [7:0] hi_byte;
      int byte_idx;
      prev_href = 1'b0;
      prev_vs   = 1'b0;
      hi_byte   = 8'h00;
      byte_idx  = 0;
      forever begin
         @(negedge clk);
         if (CamVSYNC === 1'b1 && !prev_vs) frame_lines = 0;
         if (HREF === 1'b1 && !prev_href) begin
            frame_lines++;
            byte_idx = 0;
         end
         if (HREF === 1'b1) begin
            if (byte_idx % 2 == 0) hi_byte = PixData;
            else if (byte_idx / 2 < HA) cur_pix[byte_idx / 2] = {hi_byte, PixData};
            byte_idx++;
         end
         prev_href = (HREF === 1'b1);
         prev_vs   = (CamVSYNC === 1'b1);
      end
   end

   function automatic logic sig_val(input int sel);
      case (sel)
         0:       return HREF;
         1:       return CamVSYNC;
         2:       return frameDone;
         default: return (lineCount == 10'd2) && HREF;
      endcase
   endfunction

   task automatic wait_sig(input int sel, input logic lvl, input int budget, input string name);
      bit found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (sig_val(sel) === lvl) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check(name, 32'(found), 32'd1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [7:0] bars_bytes [16];
      logic [7:0] ramp_bytes [16];
      logic [7:0] got_bytes  [16];
      int k, nz;

      bars_bytes = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                     8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
      ramp_bytes = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03,
                     8'h00, 8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 8'h07};

      resetN     = 1'b0;
      enable     = 1'b0;
      patternSel = 2'd0;
      repeat (3) @(negedge clk);
      check("rst_vsync", CamVSYNC, 0);
      check("rst_href", HREF, 0);
      check("rst_pix", PixData, 0);
      check("rst_fdone", frameDone, 0);
      check("rst_linecount", lineCount, 0);
      resetN = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_vsync", CamVSYNC, 0);

      // Frame 1: colour bars; timing, first-line bytes, pattern change and enable drop mid-frame.
      enable = 1'b1;
      wait_sig(1, 1'b1, 4, "vsync_rise");
      k = 0;
      while (CamVSYNC === 1'b1 && k < 200) begin
         k++;
         @(negedge clk);
      end
      check("vsync_len", k, 20);
      k = 0;
      while (CamVSYNC === 1'b0 && HREF === 1'b0 && k < 200) begin
         k++;
         @(negedge clk);
      end
      check("vback_len", k, 20);
      k = 0;
      while (HREF === 1'b1 && k < 64) begin
         if (k < 16) got_bytes[k] = PixData;
         k++;
         @(negedge clk);
      end
      check("href_len", k, 16);
      for (int i = 0; i < 16; i++) check("bars_byte", got_bytes[i], bars_bytes[i]);

      patternSel = 2'd3;
      wait_sig(3, 1'b1, 100, "reach_line2");
      enable = 1'b0;
      wait_sig(2, 1'b1, 200, "frame1_done");
      check("lines_sent", frame_lines, 4);
      for (int x = 0; x < HA; x++) check("bars_persist", cur_pix[x], bar_ref(x));
      @(negedge clk);
      check("fdone_width", frameDone, 0);
      k = 0;
      repeat (60) begin
         @(negedge clk);
         if (CamVSYNC !== 1'b0 || HREF !== 1'b0) k++;
      end
      check("idle_quiet", k, 0);

      // Frame 2: solid colour sampled at VSYNC entry; then back-to-back into a ramp frame.
      enable = 1'b1;
      wait_sig(0, 1'b1, 60, "f2_href_rise");
      wait_sig(0, 1'b0, 20, "f2_href_fall");
      for (int x = 0; x < HA; x++) check("solid_pix", cur_pix[x], 16'hF800);
      patternSel = 2'd1;
      wait_sig(2, 1'b1, 200, "frame2_done");
      @(negedge clk);
      check("b2b_vsync", CamVSYNC, 1);

      // Frame 3: ramp bytes and horizontal blanking.
      wait_sig(0, 1'b1, 60, "f3_href_rise");
      k = 0;
      while (HREF === 1'b1 && k < 64) begin
         if (k < 16) got_bytes[k] = PixData;
         k++;
         @(negedge clk);
      end
      check("ramp_href_len", k, 16);
      for (int i = 0; i < 16; i++) check("ramp_byte", got_bytes[i], ramp_bytes[i]);
      k  = 0;
      nz = 0;
      while (HREF === 1'b0 && k < 50) begin
         if (PixData !== 8'h00) nz++;
         k++;
         @(negedge clk);
      end
      check("hblank_len", k, 4);
      check("hblank_pix", nz, 0);

      // Asynchronous reset in the middle of an active line, then restart from VSYNC.
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2;
      resetN = 1'b0;
      #1;
      check("async_href", HREF, 0);
      check("async_pix", PixData, 0);
      check("async_vsync", CamVSYNC, 0);
      @(negedge clk);
      resetN = 1'b1;
      wait_sig(1, 1'b1, 4, "restart_vsync_rise");
      k = 0;
      while (CamVSYNC === 1'b1 && k < 200) begin
         k++;
         @(negedge clk);
      end
      check("restart_vsync_len", k, 20);
      enable = 1'b0;
      wait_sig(2, 1'b1, 200, "restart_done");
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
